// File: rtl/mersenne_pkg.sv
// Shared types and helpers for the Mersenne trial-factoring modpow controller.
package mersenne_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_MUL    = 3'd2,
    S_ISSUE  = 3'd3,
    S_ARM    = 3'd4,
    S_WAIT   = 3'd5,
    S_NEXT   = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  localparam logic ERR_FLAG = 1'b1;

  // Divider operand width: holds (r*r) << 1 for any r < 2^width.
  function automatic int divw_of(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/mersenne_modpow_ctrl_if.sv
// Controller-to-divider bus for the shift-and-subtract modulo divider.
interface mersenne_modpow_ctrl_if #(
  parameter int DIVW = 65
);
  // div_start is a one-cycle pulse, only ever raised while div_finished is high;
  // div_numerator/div_denominator stay stable until div_finished returns high,
  // at which point div_remainder holds numerator mod denominator.
  logic            div_start;
  logic [DIVW-1:0] div_numerator;
  logic [DIVW-1:0] div_denominator;
  logic [DIVW-1:0] div_remainder;
  logic            div_finished;

  modport master (
    output div_start, div_numerator, div_denominator,
    input  div_remainder, div_finished
  );

  modport slave (
    input  div_start, div_numerator, div_denominator,
    output div_remainder, div_finished
  );
endinterface

// File: rtl/mersenne_modpow_ctrl.sv
// Sequences 2^P mod Q by left-to-right square-and-double through an external
// modulo divider and flags whether Q divides 2^P - 1.
module mersenne_modpow_ctrl
  import mersenne_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXPW  = 32,
  parameter int DIVW  = divw_of(WIDTH)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic [EXPW-1:0]         exponent,
  input  logic [WIDTH-1:0]        candidate,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic                    is_factor,
  output logic                    err,
  output state_t                  state_dbg,
  mersenne_modpow_ctrl_if.master  div
);

  localparam int IW = (EXPW > 1) ? $clog2(EXPW) : 1;

  state_t            state_q, state_d;
  logic [EXPW-1:0]   p_q, p_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIVW-1:0]   num_q, num_d;
  logic              div_start_q, div_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              is_factor_q, is_factor_d;
  logic              err_q, err_d;
  logic [2*WIDTH-1:0] sq;

  assign sq = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, r_q};

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    r_d         = r_q;
    idx_d       = idx_q;
    num_d       = num_q;
    div_start_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    is_factor_d = is_factor_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d         = exponent;
          q_d         = candidate;
          r_d         = {{(WIDTH-1){1'b0}}, 1'b1};
          idx_d       = IW'(EXPW - 1);
          busy_d      = 1'b1;
          result_d    = '0;
          is_factor_d = 1'b0;
          err_d       = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        // Q of 0 or 1 has a fixed answer; the divider is never touched.
        if (q_q == '0) begin
          err_d    = ERR_FLAG;
          result_d = '0;
          state_d  = S_FINISH;
        end else if (q_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          result_d = '0;
          state_d  = S_FINISH;
        end else begin
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        num_d   = DIVW'(sq) << p_q[idx_q];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // A divider left running by a mid-job reset must drain first.
        if (div.div_finished) begin
          div_start_d = 1'b1;
          state_d     = S_ARM;
        end
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (div.div_finished) begin
          r_d     = div.div_remainder[WIDTH-1:0];
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          result_d = r_q;
          state_d  = S_FINISH;
        end else begin
          idx_d    = idx_q - 1'b1;
          state_d  = S_MUL;
        end
      end
      S_FINISH: begin
        is_factor_d = !err_q && (result_q == {{(WIDTH-1){1'b0}}, 1'b1});
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      idx_q       <= IW'(EXPW - 1);
      num_q       <= '0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      is_factor_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      is_factor_q <= is_factor_d;
      err_q       <= err_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign result              = result_q;
  assign is_factor           = is_factor_q;
  assign err                 = err_q;
  assign state_dbg           = state_q;
  assign div.div_start       = div_start_q;
  assign div.div_numerator   = num_q;
  assign div.div_denominator = DIVW'(q_q);

endmodule

// File: tb/tb_mersenne_modpow_ctrl.sv
// Bench for mersenne_modpow_ctrl: behavioural divider plus modpow reference model.
module tb_mersenne_modpow_ctrl;
  import mersenne_pkg::*;

  localparam int WIDTH   = 32;
  localparam int EXPW    = 32;
  localparam int DIVW    = 2 * WIDTH + 1;
  localparam int LAT_FULL = 3 + EXPW * (DIVW + 4);
  localparam int LIMIT   = 6000;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic dv_rst;
  always #5 sys_clk = ~sys_clk;

  logic             start;
  logic [EXPW-1:0]  exponent;
  logic [WIDTH-1:0] candidate;
  logic             busy, done, is_factor, err;
  logic [WIDTH-1:0] result;
  state_t           state_dbg;

  mersenne_modpow_ctrl_if #(.DIVW(DIVW)) dif ();

  mersenne_modpow_ctrl #(.WIDTH(WIDTH), .EXPW(EXPW), .DIVW(DIVW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .exponent  (exponent),
    .candidate (candidate),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .is_factor (is_factor),
    .err       (err),
    .state_dbg (state_dbg),
    .div       (dif)
  );

  // Multi-cycle divider stand-in: busy for DIVW cycles, independent of sys_rst.
  int              dv_cnt;
  logic [DIVW-1:0] dv_num, dv_den;
  always @(posedge sys_clk or posedge dv_rst) begin
    if (dv_rst) begin
      dif.div_finished  <= 1'b1;
      dif.div_remainder <= '0;
      dv_cnt            <= 0;
      dv_num            <= '0;
      dv_den            <= '0;
    end else if (dif.div_start && dif.div_finished) begin
      dv_num           <= dif.div_numerator;
      dv_den           <= dif.div_denominator;
      dv_cnt           <= DIVW - 1;
      dif.div_finished <= 1'b0;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) begin
        dif.div_finished  <= 1'b1;
        dif.div_remainder <= dv_num % dv_den;
      end
    end
  end

  int dstart_cnt = 0;
  always @(posedge sys_clk) if (dif.div_start) dstart_cnt <= dstart_cnt + 1;

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge sys_clk)
    if (dif.div_start) check("div_start_when_idle", 64'(dif.div_finished), 64'd1);

  // 2^P mod Q with plain integer arithmetic.
  function automatic logic [WIDTH-1:0] ref_modpow(input logic [EXPW-1:0] p, input logic [WIDTH-1:0] q);
    longint unsigned r, m;
    if (q <= 1) return '0;
    m = 64'(q);
    r = 1;
    for (int i = EXPW - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (p[i]) r = (r * 2) % m;
    end
    return r[WIDTH-1:0];
  endfunction

  // driver
  task automatic run_job(input logic [EXPW-1:0] p, input logic [WIDTH-1:0] q,
                         input bit inject, output int lat);
    @(negedge sys_clk);
    start = 1'b1; exponent = p; candidate = q;
    @(negedge sys_clk);
    start = 1'b0;
    lat = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    while (!done && lat < LIMIT) begin
      if (inject && lat == 50) begin
        start = 1'b1; exponent = 32'd4; candidate = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge sys_clk);
      lat++;
    end
    start = 1'b0;
    check("done_within_limit", 64'(done), 64'd1);
  endtask

  task automatic do_job(input logic [EXPW-1:0] p, input logic [WIDTH-1:0] q,
                        input bit inject, input bit chk_lat);
    int lat;
    int ds0;
    logic [WIDTH-1:0] want;
    ds0 = dstart_cnt;
    exp_q.push_back(ref_modpow(p, q));
    run_job(p, q, inject, lat);
    want = exp_q.pop_front();
    check("result", 64'(result), 64'(want));
    check("err", 64'(err), 64'(q == 0));
    check("is_factor", 64'(is_factor), 64'(q != 0 && want == 1));
    check("busy_at_done", 64'(busy), 64'd0);
    if (chk_lat) check("latency", 64'(lat), (q <= 1) ? 64'd3 : 64'(LAT_FULL));
    check("div_start_count", 64'(dstart_cnt - ds0), (q <= 1) ? 64'd0 : 64'(EXPW));
    @(negedge sys_clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("result_held", 64'(result), 64'(want));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_is_factor"}, 64'(is_factor), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_div_start"}, 64'(dif.div_start), 64'd0);
    check({tag, "_numerator"}, 64'(dif.div_numerator), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(S_IDLE));
  endtask

  initial begin
    int lat;
    int n;
    logic [WIDTH-1:0] rq;
    dv_rst = 1'b1; sys_rst = 1'b1;
    start = 1'b0; exponent = '0; candidate = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge sys_clk);
    dv_rst = 1'b0; sys_rst = 1'b0;

    do_job(32'd11, 32'd23, 1'b0, 1'b1);
    check("p11_q7_const", 64'(ref_modpow(32'd11, 32'd7)), 64'd4);
    do_job(32'd11, 32'd7, 1'b0, 1'b1);
    do_job(32'd67, 32'd193707721, 1'b0, 1'b1);
    check("cole_factor_flag", 64'(is_factor), 64'd1);
    do_job(32'd67, 32'd193707723, 1'b0, 1'b1);
    do_job(32'd12345, 32'd0, 1'b0, 1'b1);
    do_job(32'd99, 32'd1, 1'b0, 1'b1);
    do_job(32'd0, 32'd5, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      rq = $urandom | 32'h1;
      if (i == 4) rq = 32'($urandom_range(2, 50));
      do_job($urandom, rq, 1'b0, 1'b1);
    end

    // reset in the middle of a divider operation
    @(negedge sys_clk);
    start = 1'b1; exponent = 32'd11; candidate = 32'd23;
    @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (state_dbg != S_WAIT && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("reached_wait", 64'(state_dbg == S_WAIT), 64'd1);
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("midjob_reset");
    @(negedge sys_clk);
    check("no_done_in_reset", 64'(done), 64'd0);
    sys_rst = 1'b0;
    exp_q.push_back(ref_modpow(32'd11, 32'd23));
    run_job(32'd11, 32'd23, 1'b0, lat);
    check("restart_result", 64'(result), 64'(exp_q.pop_front()));
    check("restart_is_factor", 64'(is_factor), 64'd1);
    check("restart_waited_for_divider", 64'(lat > LAT_FULL), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mersenne_modpow_ctrl.md
Name: mersenne_modpow_ctrl

Overview:
- Sequencing controller for the shift-and-subtract modulo divider in the Mersenne trial-factoring datapath.
- Computes R = 2^P mod Q by left-to-right square-and-double.
- Each step forms r*r (times 2 if the exponent bit is 1), issues it to the divider as numerator with Q as denominator, and takes the remainder as the new r.
- Reports whether Q divides 2^P - 1, i.e. whether R == 1.

Parameters:
- WIDTH, 32, bit width of candidate Q and of result/working residue r.
- EXPW, 32, bit width of exponent P. The block iterates over all EXPW bits, MSB first.
- DIVW, 2*WIDTH+1, width of the divider numerator/denominator ports. The divider instance must use BITWIDTH=DIVW.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- exponent  in  EXPW  P, captured on accepted start.
- candidate  in  WIDTH  Q, captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result/is_factor/err are valid.
- result  out  WIDTH  2^P mod Q; held until the next accepted start.
- is_factor  out  1  result==1 and err==0; held with result.
- err  out  1  Q==0 on the accepted job; held with result.
- div_start  out  1  one-cycle pulse to divider start.
- div_numerator  out  DIVW  product operand; stable from div_start until div_finished returns high.
- div_denominator  out  DIVW  Q zero-extended.
- div_remainder  in  DIVW  divider remainder; only the low WIDTH bits are used, since the remainder is < Q.
- div_finished  in  1  divider idle/complete flag. It is high when idle and goes low the cycle after div_start.

Behaviour:
- Reset (async, sys_rst=1): state=IDLE; busy=0, done=0, div_start=0, result=0, is_factor=0, err=0, div_numerator=0, r=0, bit index=EXPW-1.
- States: IDLE, CHECK, MUL, ISSUE, ARM, WAIT, NEXT, FINISH.
- IDLE: on start, latch P and Q, set r=1, set index=EXPW-1, go to CHECK. busy rises the next cycle.
- CHECK:
  - Q==0: err=1, result=0, go to FINISH.
  - Q==1: result=0, go to FINISH. The divider is never used.
  - Otherwise go to MUL.
- MUL: register div_numerator = (r*r) << P[index]. Width: r<Q<2^WIDTH, so the product is < 2^(2*WIDTH+1) = 2^DIVW. Go to ISSUE.
- ISSUE: wait until div_finished==1. This covers a divider still running after a mid-job reset. Then pulse div_start for one cycle and go to ARM.
- ARM: one-cycle guard so div_finished has deasserted. Go to WAIT.
- WAIT: on div_finished==1, r = div_remainder[WIDTH-1:0], go to NEXT.
- NEXT: if index==0, result=r and go to FINISH. Otherwise decrement index and go to MUL.
- FINISH:
  - is_factor = (err==0 && result==1).
  - Pulse done for one cycle, drop busy, return to IDLE.
- Timing: a new start is accepted in the same cycle done is seen only if the FSM is already in IDLE. Back-to-back jobs therefore start no earlier than the cycle after done.
- Latency (Q>1, divider idle at start): exactly 3 + EXPW*(DIVW+4) cycles from start to done. Degenerate Q (0 or 1): 3 cycles.
- Boundaries:
  - start while busy is ignored, with no effect on latched operands.
  - P=0 gives r=1 through all squarings, so result=1.
  - div_start is never asserted while div_finished==0.
  - Reset mid-job returns to IDLE immediately with outputs at reset values; no done pulse is produced.

Decomposition:
- Shared package (mersenne_pkg): FSM state encoding constants (3-bit), DIVW derivation function, and an ERR/flag bit constant.
- Instantiate the existing modulo divider in a thin top wrapper, mersenne_tf_top, alongside this controller. The controller itself has no sub-module; its multiplier is one inferred r*r expression.

Test Plan:
- P=11, Q=23 -> done after 3+32*69 cycles; result=1, is_factor=1, err=0.
- P=11, Q=7 -> result=4, is_factor=0.
- P=67, Q=193707721 -> result=1, is_factor=1. Then P=67, Q=193707723 -> is_factor=0, with result matching the reference model's 2^67 mod Q.
- Q=0 (any P) -> done 3 cycles after start, err=1, result=0, div_start never pulses. Q=1 -> result=0, is_factor=0, err=0.
- P=0, Q=5 -> result=1, is_factor=1. start pulsed again mid-job with Q=7 -> ignored; first job's result unchanged.
- sys_rst asserted during WAIT of a P=11, Q=23 job -> outputs zero immediately, no done. Restart while the divider is still busy -> ISSUE holds until div_finished=1, then correct result=1.
